// File: rtl/io_interrupt_unit_team1.sv
// Keyboard/printer serial I/O (INPR/FGI, OUTR/FGO) and interrupt control (IEN, R)
// for the basic-computer datapath. All outputs come straight from registers.
module io_interrupt_unit_team1 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] ac_low,
  input  logic       inp_exec,
  input  logic       out_exec,
  input  logic       ion,
  input  logic       iof,
  input  logic       r_check,
  input  logic       int_ack,
  output logic [7:0] inpr,
  output logic       fgi,
  output logic       fgo,
  output logic       ien,
  output logic       r,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

  // ---------------- receiver ----------------
  ser_state_e      rx_state_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            rx_done_q;
  logic            rx_frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q     <= S_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_done_q      <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_done_q      <= 1'b0;
      rx_frame_err_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          if (!rx) begin
            rx_state_q <= S_START;
            rx_cnt_q   <= '0;
          end
        end
        S_START: begin
          // Half-bit resample rejects short low glitches on the idle line.
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == CNT_FULL) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == CNT_FULL) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
            if (rx) begin
              rx_done_q <= 1'b1;
            end else begin
              rx_frame_err_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- INPR / FGI / overrun / IEN / R ----------------
  logic [7:0] inpr_q, inpr_d;
  logic       fgi_q, fgi_d;
  logic       ovr_q, ovr_d;
  logic       ien_q, ien_d;
  logic       r_q, r_d;
  logic       fgo_q;

  always_comb begin
    inpr_d = inpr_q;
    fgi_d  = fgi_q;
    ovr_d  = ovr_q;
    // A same-cycle INP consumes the old byte, so the new one may replace it.
    if (rx_done_q) begin
      if (!fgi_q || inp_exec) begin
        inpr_d = rx_shift_q;
        fgi_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (inp_exec) begin
      fgi_d = 1'b0;
    end
  end

  always_comb begin
    ien_d = ien_q;
    if (iof || int_ack) begin
      ien_d = 1'b0;
    end else if (ion) begin
      ien_d = 1'b1;
    end
    r_d = r_q;
    if (int_ack) begin
      r_d = 1'b0;
    end else if (ien_q && (fgi_q || fgo_q) && r_check) begin
      r_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ien_q  <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      inpr_q <= inpr_d;
      fgi_q  <= fgi_d;
      ovr_q  <= ovr_d;
      ien_q  <= ien_d;
      r_q    <= r_d;
    end
  end

  // ---------------- transmitter ----------------
  ser_state_e      tx_state_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      outr_q;
  logic            tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      outr_q     <= '0;
      tx_q       <= 1'b1;
      fgo_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          // fgo is low for the whole frame, so OUT mid-frame never reaches here.
          if (out_exec && fgo_q) begin
            outr_q     <= ac_low;
            fgo_q      <= 1'b0;
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == CNT_FULL) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= outr_q[0];
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == CNT_FULL) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_q     <= outr_q[tx_bit_q + 3'd1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == CNT_FULL) begin
            tx_cnt_q   <= '0;
            fgo_q      <= 1'b1;
            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign tx           = tx_q;
  assign inpr         = inpr_q;
  assign fgi          = fgi_q;
  assign fgo          = fgo_q;
  assign ien          = ien_q;
  assign r            = r_q;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = rx_frame_err_q;

endmodule
